// File: rtl/timer_a_if.sv
// Timer_A memory-bus port bundle.
// The pipeline side is the master; the peripheral is the slave.
interface timer_a_if;
  logic [15:0] MAB_in;
  logic [15:0] MDB_in;
  logic        MW;
  logic        BW;
  logic [15:0] MDB_periph_out;
  logic        periph_sel;
  logic        periph_write_done;
  logic        TA_irq;

  modport master (
    output MAB_in, MDB_in, MW, BW,
    input  MDB_periph_out, periph_sel,
    input  periph_write_done, TA_irq
  );

  modport slave (
    input  MAB_in, MDB_in, MW, BW,
    output MDB_periph_out, periph_sel,
    output periph_write_done, TA_irq
  );
endinterface

// File: rtl/timer_a.sv
// Timer_A: 16-bit prescaled counter with one compare channel.
// Memory-mapped responder; stop, up, continuous and up/down modes.
module timer_a #(
  parameter logic [15:0] TACTL_ADDR   = 16'h0160,
  parameter logic [15:0] TACCTL0_ADDR = 16'h0162,
  parameter logic [15:0] TAR_ADDR     = 16'h0170,
  parameter logic [15:0] TACCR0_ADDR  = 16'h0172
) (
  input logic      clk,
  input logic      rst,
  timer_a_if.slave bus
);

  logic [1:0]  r_tassel;
  logic [1:0]  r_id;
  logic [1:0]  r_mc;
  logic        r_taie;
  logic        r_taifg;
  logic        r_ccie;
  logic        r_ccifg;
  logic [15:0] r_tar;
  logic [15:0] r_taccr0;
  logic [2:0]  r_pre;
  logic        r_up;
  logic        r_acc;
  logic [15:0] r_addr;
  logic        r_done;

  logic        w_sel_ctl;
  logic        w_sel_cc;
  logic        w_sel_tar;
  logic        w_sel_ccr;
  logic        w_sel;
  logic        w_hold;
  logic        w_wr;
  logic [15:0] w_wdata;
  logic        w_wr_ctl;
  logic        w_wr_cc;
  logic        w_wr_tar;
  logic        w_wr_ccr;
  logic        w_clr;
  logic [2:0]  w_lim;
  logic        w_tick;
  logic [15:0] w_inc;
  logic [15:0] w_dec;
  logic [15:0] w_tar_n;
  logic        w_up_n;
  logic        w_set_taifg;
  logic        w_set_ccifg;
  logic [15:0] w_rd;

  assign w_sel_ctl = bus.MAB_in == TACTL_ADDR;
  assign w_sel_cc  = bus.MAB_in == TACCTL0_ADDR;
  assign w_sel_tar = bus.MAB_in == TAR_ADDR;
  assign w_sel_ccr = bus.MAB_in == TACCR0_ADDR;
  assign w_sel     = w_sel_ctl | w_sel_cc
                   | w_sel_tar | w_sel_ccr;

  // A held strobe on the same address was already taken once.
  assign w_hold  = r_acc & bus.MW
                 & (bus.MAB_in == r_addr);
  assign w_wr    = bus.MW & w_sel & ~w_hold;
  assign w_wdata = bus.BW ? {8'h00, bus.MDB_in[7:0]}
                          : bus.MDB_in;

  assign w_wr_ctl = w_wr & w_sel_ctl;
  assign w_wr_cc  = w_wr & w_sel_cc;
  assign w_wr_tar = w_wr & w_sel_tar;
  assign w_wr_ccr = w_wr & w_sel_ccr;
  assign w_clr    = w_wr_ctl & w_wdata[2];

  assign w_inc = r_tar + 16'd1;
  assign w_dec = r_tar - 16'd1;

  // Prescaler terminal count: 2^ID - 1.
  always_comb begin
    w_lim = 3'd0;
    unique case (r_id)
      2'd0: w_lim = 3'd0;
      2'd1: w_lim = 3'd1;
      2'd2: w_lim = 3'd3;
      2'd3: w_lim = 3'd7;
    endcase
  end

  assign w_tick = r_pre >= w_lim;

  // Next counter value, direction and hardware flag sets.
  always_comb begin
    w_tar_n     = r_tar;
    w_up_n      = r_up;
    w_set_taifg = 1'b0;
    w_set_ccifg = 1'b0;
    if (w_tick) begin
      unique case (r_mc)
        2'b00: w_tar_n = r_tar;
        2'b01: begin
          if (r_taccr0 == 16'd0) begin
            w_tar_n = 16'd0;
          end else if (r_tar >= r_taccr0) begin
            w_tar_n     = 16'd0;
            w_set_taifg = 1'b1;
          end else begin
            w_tar_n     = w_inc;
            w_set_ccifg = w_inc == r_taccr0;
          end
        end
        2'b10: begin
          w_tar_n     = w_inc;
          w_set_taifg = w_inc == 16'd0;
          w_set_ccifg = w_inc == r_taccr0;
        end
        2'b11: begin
          if (r_taccr0 == 16'd0) begin
            w_tar_n = 16'd0;
          end else if (r_up) begin
            if (r_tar > r_taccr0) begin
              w_up_n = 1'b0;
            end else begin
              w_tar_n = w_inc;
              if (w_inc == r_taccr0) begin
                w_set_ccifg = 1'b1;
                w_up_n      = 1'b0;
              end
            end
          end else begin
            w_tar_n = w_dec;
            if (w_dec == 16'd0) begin
              w_set_taifg = 1'b1;
              w_up_n      = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Bus handshake: accept flag, last address, done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= 1'b0;
      r_addr <= 16'd0;
      r_done <= 1'b0;
    end else begin
      r_acc  <= w_wr | w_hold;
      r_done <= w_wr;
      if (w_wr) r_addr <= bus.MAB_in;
    end
  end

  // Counter, prescaler and direction; TACLR beats tick and TAR write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tar <= 16'd0;
      r_pre <= 3'd0;
      r_up  <= 1'b1;
    end else if (w_clr) begin
      r_tar <= 16'd0;
      r_pre <= 3'd0;
      r_up  <= 1'b1;
    end else begin
      r_tar <= w_wr_tar ? w_wdata : w_tar_n;
      r_pre <= w_tick ? 3'd0 : r_pre + 3'd1;
      r_up  <= w_up_n;
    end
  end

  // Control registers; a hardware flag set beats a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tassel <= 2'd0;
      r_id     <= 2'd0;
      r_mc     <= 2'd0;
      r_taie   <= 1'b0;
      r_taifg  <= 1'b0;
      r_ccie   <= 1'b0;
      r_ccifg  <= 1'b0;
      r_taccr0 <= 16'd0;
    end else begin
      if (w_wr_ctl) begin
        r_tassel <= w_wdata[9:8];
        r_id     <= w_wdata[7:6];
        r_mc     <= w_wdata[5:4];
        r_taie   <= w_wdata[1];
      end
      r_taifg <= (w_wr_ctl ? w_wdata[0] : r_taifg)
               | w_set_taifg;
      if (w_wr_cc) r_ccie <= w_wdata[4];
      r_ccifg <= (w_wr_cc ? w_wdata[0] : r_ccifg)
               | w_set_ccifg;
      if (w_wr_ccr) r_taccr0 <= w_wdata;
    end
  end

  // Read mux of the selected register.
  always_comb begin
    w_rd = 16'd0;
    unique case (1'b1)
      w_sel_ctl: w_rd = {6'd0, r_tassel, r_id, r_mc,
                         2'b00, r_taie, r_taifg};
      w_sel_cc:  w_rd = {11'd0, r_ccie, 3'd0, r_ccifg};
      w_sel_tar: w_rd = r_tar;
      w_sel_ccr: w_rd = r_taccr0;
      default:   w_rd = 16'd0;
    endcase
  end

  assign bus.MDB_periph_out = bus.BW ? {8'h00, w_rd[7:0]}
                                     : w_rd;
  assign bus.periph_sel        = w_sel;
  assign bus.periph_write_done = r_done;
  assign bus.TA_irq = (r_taie & r_taifg)
                    | (r_ccie & r_ccifg);

endmodule

// File: tb/tb_timer_a.sv
// Bench for timer_a: directed checks plus randomized bus traffic
// compared each cycle with a behavioural model of the timer.
module tb_timer_a;

  localparam logic [15:0] A_CTL = 16'h0160;
  localparam logic [15:0] A_CC  = 16'h0162;
  localparam logic [15:0] A_TAR = 16'h0170;
  localparam logic [15:0] A_CCR = 16'h0172;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  timer_a_if bus();

  timer_a dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] m_tar, m_ccr0, m_addr;
  logic [1:0]  m_tassel, m_id, m_mc;
  logic        m_taie, m_taifg, m_ccie, m_ccifg;
  logic        m_up, m_acc, m_done;
  int          m_ph;

  task automatic m_reset();
    m_tar = 0; m_ccr0 = 0; m_addr = 0;
    m_tassel = 0; m_id = 0; m_mc = 0;
    m_taie = 0; m_taifg = 0; m_ccie = 0; m_ccifg = 0;
    m_up = 1; m_acc = 0; m_done = 0; m_ph = 0;
  endtask

  function automatic logic m_sel(input logic [15:0] a);
    return a == A_CTL || a == A_CC || a == A_TAR || a == A_CCR;
  endfunction

  function automatic logic [15:0] m_read(
    input logic [15:0] a, input logic bw);
    logic [15:0] v;
    v = 16'd0;
    if (a == A_CTL)
      v = {6'd0, m_tassel, m_id, m_mc, 2'b00, m_taie, m_taifg};
    else if (a == A_CC)
      v = {11'd0, m_ccie, 3'd0, m_ccifg};
    else if (a == A_TAR) v = m_tar;
    else if (a == A_CCR) v = m_ccr0;
    return bw ? (v & 16'h00FF) : v;
  endfunction

  function automatic logic m_irq();
    return (m_taie && m_taifg) || (m_ccie && m_ccifg);
  endfunction

  // Advance the model by one clock using the bus as driven now.
  task automatic m_edge();
    logic        hit, wr, tick, sa, sc;
    logic [15:0] d, t;
    int          div;
    hit = m_acc && bus.MW && bus.MAB_in == m_addr;
    wr  = bus.MW && m_sel(bus.MAB_in) && !hit;
    d   = bus.BW ? {8'h00, bus.MDB_in[7:0]} : bus.MDB_in;
    div  = 1 << m_id;
    tick = m_ph >= div - 1;
    m_ph = tick ? 0 : m_ph + 1;
    sa = 0; sc = 0; t = m_tar;
    if (tick && m_mc == 2'd1) begin
      if (m_ccr0 == 0) t = 0;
      else if (m_tar >= m_ccr0) begin t = 0; sa = 1; end
      else begin t = m_tar + 1; sc = (t == m_ccr0); end
    end else if (tick && m_mc == 2'd2) begin
      t = m_tar + 1;
      sa = (t == 0);
      sc = (t == m_ccr0);
    end else if (tick && m_mc == 2'd3) begin
      if (m_ccr0 == 0) t = 0;
      else if (m_up && m_tar > m_ccr0) m_up = 0;
      else if (m_up) begin
        t = m_tar + 1;
        if (t == m_ccr0) begin sc = 1; m_up = 0; end
      end else begin
        t = m_tar - 1;
        if (t == 0) begin sa = 1; m_up = 1; end
      end
    end
    if (wr && bus.MAB_in == A_CTL) begin
      m_tassel = d[9:8]; m_id = d[7:6]; m_mc = d[5:4];
      m_taie = d[1]; m_taifg = d[0];
      if (d[2]) begin t = 0; m_ph = 0; m_up = 1; end
    end else if (wr && bus.MAB_in == A_CC) begin
      m_ccie = d[4]; m_ccifg = d[0];
    end else if (wr && bus.MAB_in == A_TAR) begin
      t = d;
    end else if (wr && bus.MAB_in == A_CCR) begin
      m_ccr0 = d;
    end
    m_tar   = t;
    m_taifg = m_taifg | sa;
    m_ccifg = m_ccifg | sc;
    m_done  = wr;
    m_acc   = wr || hit;
    if (wr) m_addr = bus.MAB_in;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    if (!rst) m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic bw,
                    output logic [15:0] d);
    bus.MAB_in = a;
    bus.BW = bw;
    #1;
    d = bus.MDB_periph_out;
    bus.BW = 1'b0;
  endtask

  // Compare outputs and, when idle, every register with the model.
  task automatic chk_state(input string tag);
    logic [15:0] sv, d;
    chk({tag, "_done"}, {15'd0, bus.periph_write_done},
        {15'd0, m_done});
    chk({tag, "_irq"}, {15'd0, bus.TA_irq}, {15'd0, m_irq()});
    if (!bus.MW) begin
      sv = bus.MAB_in;
      rd(A_CTL, 1'b0, d); chk({tag, "_ctl"}, d, m_read(A_CTL, 0));
      rd(A_CC, 1'b0, d);  chk({tag, "_cc"}, d, m_read(A_CC, 0));
      rd(A_TAR, 1'b0, d); chk({tag, "_tar"}, d, m_read(A_TAR, 0));
      rd(A_CCR, 1'b1, d); chk({tag, "_ccrb"}, d, m_read(A_CCR, 1));
      bus.MAB_in = sv;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d,
                    input logic bw, input int hold);
    bus.MAB_in = a; bus.MDB_in = d;
    bus.BW = bw;    bus.MW = 1'b1;
    for (int k = 0; k < hold; k++) begin
      cyc();
      chk_state("wr");
    end
    bus.MW = 1'b0;
    bus.BW = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] ta [5] = '{1, 2, 3, 4, 0};
    logic [15:0] ca [5] = '{0, 0, 0, 1, 1};
    logic [15:0] la [5] = '{16'h12, 16'h12, 16'h12, 16'h12, 16'h13};
    logic [15:0] ia [5] = '{0, 0, 0, 0, 1};
    logic [15:0] tu [7] = '{1, 2, 3, 2, 1, 0, 1};
    logic [15:0] cu [7] = '{0, 0, 1, 1, 1, 1, 1};
    logic [15:0] lu [7] = '{16'h30, 16'h30, 16'h30, 16'h30,
                            16'h30, 16'h31, 16'h31};
    logic [15:0] addrs [4] = '{A_CTL, A_CC, A_TAR, A_CCR};
    bit found;

    bus.MAB_in = 0; bus.MDB_in = 0; bus.MW = 0; bus.BW = 0;
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_done", {15'd0, bus.periph_write_done}, 16'd0);
    chk("rst_irq", {15'd0, bus.TA_irq}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], 1'b0, d);
      chk("rst_reg", d, 16'd0);
    end

    bus.MAB_in = A_TAR; bus.MDB_in = 16'h1234;
    bus.BW = 1'b0;      bus.MW = 1'b1;
    cyc(); chk("held_pulse", {15'd0, bus.periph_write_done}, 16'd1);
    cyc(); chk("held_once1", {15'd0, bus.periph_write_done}, 16'd0);
    cyc(); chk("held_once2", {15'd0, bus.periph_write_done}, 16'd0);
    bus.MW = 1'b0;
    rd(A_TAR, 1'b0, d); chk("held_tar", d, 16'h1234);

    wr(A_CCR, 16'hABCD, 1'b1, 1);
    rd(A_CCR, 1'b0, d); chk("byte_wr", d, 16'h00CD);
    rd(A_TAR, 1'b1, d); chk("byte_rd", d, 16'h0034);

    wr(A_TAR, 16'h0000, 1'b0, 1);
    wr(A_CCR, 16'h0004, 1'b0, 1);
    wr(A_CTL, 16'h0012, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      rd(A_TAR, 1'b0, d); chk("up_tar", d, ta[i]);
      rd(A_CC, 1'b0, d);  chk("up_cc", d, ca[i]);
      rd(A_CTL, 1'b0, d); chk("up_ctl", d, la[i]);
      chk("up_irq", {15'd0, bus.TA_irq}, ia[i]);
      chk_state("up");
    end

    wr(A_CTL, 16'h0004, 1'b0, 1);
    wr(A_CC, 16'h0000, 1'b0, 1);
    wr(A_CCR, 16'h0003, 1'b0, 1);
    wr(A_CTL, 16'h0030, 1'b0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      rd(A_TAR, 1'b0, d); chk("ud_tar", d, tu[i]);
      rd(A_CC, 1'b0, d);  chk("ud_cc", d, cu[i]);
      rd(A_CTL, 1'b0, d); chk("ud_ctl", d, lu[i]);
      chk_state("ud");
    end

    wr(A_CTL, 16'h0004, 1'b0, 1);
    wr(A_TAR, 16'hFFFF, 1'b0, 1);
    wr(A_CTL, 16'h0020, 1'b0, 1);
    cyc();
    rd(A_TAR, 1'b0, d); chk("wrap_tar", d, 16'h0000);
    rd(A_CTL, 1'b0, d); chk("wrap_ctl", d, 16'h0021);

    wr(A_CTL, 16'h00E4, 1'b0, 1);
    repeat (7) cyc();
    rd(A_TAR, 1'b0, d); chk("div8_7", d, 16'd0);
    cyc();
    rd(A_TAR, 1'b0, d); chk("div8_8", d, 16'd1);
    repeat (7) cyc();
    rd(A_TAR, 1'b0, d); chk("div8_15", d, 16'd1);
    cyc();
    rd(A_TAR, 1'b0, d); chk("div8_16", d, 16'd2);
    chk_state("div8");

    wr(A_CTL, 16'h0020, 1'b0, 1);
    repeat (5) cyc();
    wr(A_CTL, 16'h0024, 1'b0, 1);
    rd(A_TAR, 1'b0, d); chk("clr_tick", d, 16'd0);

    wr(A_CCR, 16'h0003, 1'b0, 1);
    wr(A_CTL, 16'h0014, 1'b0, 1);
    rd(A_CTL, 1'b0, d); chk("race_pre", d & 16'h1, 16'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_tar == 16'd3) found = 1;
      else cyc();
    end
    chk("race_sync", {15'd0, found}, 16'd1);
    wr(A_CTL, 16'h0010, 1'b0, 1);
    rd(A_CTL, 1'b0, d); chk("race_taifg", d, 16'h0011);
    rd(A_TAR, 1'b0, d); chk("race_tar", d, 16'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [15:0] a, v;
        a = addrs[$urandom_range(0, 3)];
        v = $urandom();
        if (a == A_CCR) v = 16'($urandom_range(0, 12));
        if (a == A_TAR)
          v = $urandom_range(0, 1) ? 16'($urandom_range(0, 20))
                                   : 16'hFFF0 | 16'($urandom_range(0, 15));
        if (a == A_CTL && $urandom_range(0, 1)) v = v & 16'hFF3F;
        wr(a, v, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else begin
        cyc();
        chk_state("rnd");
      end
    end

    wr(A_CCR, 16'h0005, 1'b0, 1);
    wr(A_CTL, 16'h0026, 1'b0, 1);
    repeat (9) cyc();
    bus.MAB_in = A_TAR; bus.MDB_in = 16'h5555; bus.MW = 1'b1;
    #3 rst = 1'b1;
    m_reset();
    #1;
    bus.MW = 1'b0;
    chk("arst_done", {15'd0, bus.periph_write_done}, 16'd0);
    chk("arst_irq", {15'd0, bus.TA_irq}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i], 1'b0, d);
      chk("arst_reg", d, 16'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    chk("arst_nodone", {15'd0, bus.periph_write_done}, 16'd0);
    rd(A_TAR, 1'b0, d); chk("arst_tar", d, 16'd0);
    chk_state("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
